// File: rtl/instr_fetch_if.sv
// Fetch-unit bus bundle: instruction-memory read port
// and the valid/ready handshake toward decode.
interface instr_fetch_if;
  logic        o_imem_req;
  logic [31:0] o_imem_addr;
  logic        i_imem_valid;
  logic [31:0] i_imem_rdata;
  logic        o_valid;
  logic        i_ready;
  logic [31:0] o_instr;
  logic [31:0] o_pc;

  modport master (
    output o_imem_req,
    output o_imem_addr,
    input  i_imem_valid,
    input  i_imem_rdata,
    output o_valid,
    input  i_ready,
    output o_instr,
    output o_pc
  );

  modport slave (
    input  o_imem_req,
    input  o_imem_addr,
    output i_imem_valid,
    output i_imem_rdata,
    input  o_valid,
    output i_ready,
    input  o_instr,
    input  o_pc
  );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch: PC, single-outstanding imem reads,
// small fetch FIFO toward decode, redirect/halt/trap.
module instr_fetch #(
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic          i_clk,
  input  logic          i_rst,
  instr_fetch_if.master bus,
  input  logic          i_redirect,
  input  logic [31:0]   i_redirect_pc,
  input  logic          i_halt,
  output logic          o_halted,
  output logic          o_trap
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_DRAIN,
    S_HALTED
  } state_e;

  state_e          state_q, state_d;
  logic [31:0]     pc_q, pc_d;
  logic [31:0]     addr_q, addr_d;
  logic            req_q;
  logic            halted_q, halted_d;
  logic            trap_q, trap_d;
  logic [AW-1:0]   wr_q, rd_q;
  logic [CW-1:0]   count_q, count_d, cnt_pop;
  logic [31:0]     fifo_instr_q [FIFO_DEPTH];
  logic [31:0]     fifo_pc_q    [FIFO_DEPTH];
  logic            push, pop, flush;
  logic            bad_tgt, halt_ev;

  assign bad_tgt = i_redirect && (i_redirect_pc[1:0] != 2'b00);
  assign halt_ev = i_halt || bad_tgt;

  // Next-state: FSM, PC, FIFO push/pop/flush decisions
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    halted_d = halted_q;
    trap_d   = trap_q;
    push     = 1'b0;
    flush    = 1'b0;
    pop      = bus.o_valid && bus.i_ready;
    cnt_pop  = count_q - CW'(pop);
    if (state_q != S_HALTED && !halted_q) begin
      if (halt_ev) begin
        flush    = 1'b1;
        pop      = 1'b0;
        halted_d = 1'b1;
        trap_d   = trap_q || bad_tgt;
        state_d  = (req_q && !bus.i_imem_valid) ? S_DRAIN : S_HALTED;
      end else if (i_redirect) begin
        flush = 1'b1;
        pop   = 1'b0;
        pc_d  = i_redirect_pc;
        if (req_q && !bus.i_imem_valid) state_d = S_DRAIN;
        else                             state_d = S_REQ;
      end else begin
        unique case (state_q)
          S_IDLE: begin
            if (cnt_pop < DEPTH_C) state_d = S_REQ;
          end
          S_REQ: begin
            if (bus.i_imem_valid) begin
              push = 1'b1;
              pc_d = pc_q + 32'd4;
              if (cnt_pop + CW'(1) < DEPTH_C) state_d = S_REQ;
              else                            state_d = S_IDLE;
            end
          end
          S_DRAIN: begin
            if (bus.i_imem_valid) state_d = S_REQ;
          end
          S_HALTED: begin
          end
        endcase
      end
    end else if (state_q == S_DRAIN && bus.i_imem_valid) begin
      state_d = S_HALTED;
    end
    // a drained request keeps its old address on the bus
    addr_d  = (state_d == S_DRAIN) ? addr_q : pc_d;
    count_d = count_q + CW'(push) - CW'(pop);
  end

  // Registered FSM state, PC, outputs and FIFO storage
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q  <= S_IDLE;
      pc_q     <= RESET_ADDR;
      addr_q   <= RESET_ADDR;
      req_q    <= 1'b0;
      halted_q <= 1'b0;
      trap_q   <= 1'b0;
      wr_q     <= '0;
      rd_q     <= '0;
      count_q  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_instr_q[i] <= '0;
        fifo_pc_q[i]    <= '0;
      end
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      addr_q   <= addr_d;
      req_q    <= (state_d == S_REQ) || (state_d == S_DRAIN);
      halted_q <= halted_d;
      trap_q   <= trap_d;
      if (flush) begin
        wr_q    <= '0;
        rd_q    <= '0;
        count_q <= '0;
      end else begin
        if (push) begin
          fifo_instr_q[wr_q] <= bus.i_imem_rdata;
          fifo_pc_q[wr_q]    <= pc_q;
          wr_q               <= wr_q + AW'(1);
        end
        if (pop) rd_q <= rd_q + AW'(1);
        count_q <= count_d;
      end
    end
  end

  assign bus.o_imem_req  = req_q;
  assign bus.o_imem_addr = addr_q;
  assign bus.o_valid     = (count_q != '0);
  assign bus.o_instr     = bus.o_valid ? fifo_instr_q[rd_q] : '0;
  assign bus.o_pc        = bus.o_valid ? fifo_pc_q[rd_q] : '0;
  assign o_halted        = halted_q;
  assign o_trap          = trap_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: latency-configurable
// imem model, redirect/halt/trap/wrap/reset scenarios.
module tb_instr_fetch;

  logic        clk;
  logic        rst_n;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        halt;
  logic        halted;
  logic        trap;
  int          lat;
  int          wc;
  int          checks;
  int          failures;
  logic [31:0] old_addr;

  instr_fetch_if bus ();

  instr_fetch #(
    .RESET_ADDR (32'h0000_0000),
    .FIFO_DEPTH (2)
  ) dut (
    .i_clk         (clk),
    .i_rst         (rst_n),
    .bus           (bus),
    .i_redirect    (redirect),
    .i_redirect_pc (redirect_pc),
    .i_halt        (halt),
    .o_halted      (halted),
    .o_trap        (trap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return a ^ 32'h5A5A_0013;
  endfunction

  // imem model: responds after lat wait cycles
  always_comb begin
    bus.i_imem_valid = bus.o_imem_req && (wc >= lat);
    bus.i_imem_rdata = bus.i_imem_valid ?
                       memf(bus.o_imem_addr) : 32'h0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wc <= 0;
    else if (bus.o_imem_req && !bus.i_imem_valid) wc <= wc + 1;
    else wc <= 0;
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n    = 1'b0;
    redirect = 1'b0;
    halt     = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Check successive popped {pc,instr} starting at start
  task automatic expect_pops(input logic [31:0] start,
                             input int n,
                             input int budget,
                             input string tag);
    logic [31:0] e;
    int          got;
    e   = start;
    got = 0;
    for (int c = 0; c < budget && got < n; c++) begin
      if (bus.o_valid && bus.i_ready) begin
        chk({tag, "_pc"}, bus.o_pc, e);
        chk({tag, "_instr"}, bus.o_instr, memf(e));
        e = e + 32'd4;
        got++;
      end
      @(negedge clk);
    end
    chk({tag, "_count"}, 32'(got), 32'(n));
  endtask

  task automatic wait_req_pending(input string tag);
    int c;
    c = 0;
    while (!(bus.o_imem_req && !bus.i_imem_valid) && c < 40) begin
      @(negedge clk);
      c++;
    end
    chk({tag, "_pend"}, 32'(bus.o_imem_req && !bus.i_imem_valid), 32'd1);
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    rst_n       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    halt        = 1'b0;
    lat         = 0;
    bus.i_ready = 1'b1;

    // reset state
    @(negedge clk);
    chk("rst_req", 32'(bus.o_imem_req), 32'd0);
    chk("rst_addr", bus.o_imem_addr, 32'h0);
    chk("rst_valid", 32'(bus.o_valid), 32'd0);
    chk("rst_instr", bus.o_instr, 32'h0);
    chk("rst_pc", bus.o_pc, 32'h0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_trap", 32'(trap), 32'd0);
    rst_n = 1'b1;

    // zero-wait streaming, one instruction per cycle
    @(negedge clk);
    @(negedge clk);
    chk("zw_first_valid", 32'(bus.o_valid), 32'd1);
    expect_pops(32'h0, 6, 6, "zw");

    // latency 3, decode stalled: FIFO fills, fetch stops
    do_reset();
    lat         = 3;
    bus.i_ready = 1'b0;
    repeat (30) @(negedge clk);
    chk("full_valid", 32'(bus.o_valid), 32'd1);
    chk("full_pc", bus.o_pc, 32'h0);
    chk("full_req", 32'(bus.o_imem_req), 32'd0);
    bus.i_ready = 1'b1;
    expect_pops(32'h0, 5, 60, "resume");

    // redirect while a request is outstanding
    wait_req_pending("rd1");
    old_addr    = bus.o_imem_addr;
    redirect    = 1'b1;
    redirect_pc = 32'h100;
    @(negedge clk);
    redirect = 1'b0;
    chk("drain_valid", 32'(bus.o_valid), 32'd0);
    chk("drain_req", 32'(bus.o_imem_req), 32'd1);
    chk("drain_addr", bus.o_imem_addr, old_addr);
    expect_pops(32'h100, 2, 40, "rd1");

    // redirect coincident with response and pop
    lat = 0;
    begin
      int c;
      c = 0;
      while (!(bus.o_valid && bus.i_imem_valid) && c < 20) begin
        @(negedge clk);
        c++;
      end
      chk("rd2_sync", 32'(bus.o_valid && bus.i_imem_valid), 32'd1);
    end
    redirect    = 1'b1;
    redirect_pc = 32'h200;
    @(negedge clk);
    redirect = 1'b0;
    chk("rd2_empty", 32'(bus.o_valid), 32'd0);
    chk("rd2_addr", bus.o_imem_addr, 32'h200);
    @(negedge clk);
    chk("rd2_valid", 32'(bus.o_valid), 32'd1);
    chk("rd2_pc", bus.o_pc, 32'h200);
    chk("rd2_instr", bus.o_instr, memf(32'h200));

    // PC wraps from top of address space to zero
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    @(negedge clk);
    redirect = 1'b0;
    expect_pops(32'hFFFF_FFFC, 3, 20, "wrap");

    // misaligned redirect traps and halts
    redirect    = 1'b1;
    redirect_pc = 32'h102;
    @(negedge clk);
    redirect = 1'b0;
    chk("trap_trap", 32'(trap), 32'd1);
    chk("trap_halted", 32'(halted), 32'd1);
    chk("trap_valid", 32'(bus.o_valid), 32'd0);
    chk("trap_req", 32'(bus.o_imem_req), 32'd0);
    redirect    = 1'b1;
    redirect_pc = 32'h300;
    @(negedge clk);
    redirect = 1'b0;
    repeat (5) @(negedge clk);
    chk("trap_hold_req", 32'(bus.o_imem_req), 32'd0);
    chk("trap_hold_valid", 32'(bus.o_valid), 32'd0);

    // halt with a request pending: drain, then halted
    do_reset();
    chk("rst2_trap", 32'(trap), 32'd0);
    chk("rst2_halted", 32'(halted), 32'd0);
    lat = 3;
    wait_req_pending("halt");
    old_addr = bus.o_imem_addr;
    halt     = 1'b1;
    @(negedge clk);
    halt = 1'b0;
    chk("halt_halted", 32'(halted), 32'd1);
    chk("halt_drain_req", 32'(bus.o_imem_req), 32'd1);
    chk("halt_drain_addr", bus.o_imem_addr, old_addr);
    chk("halt_valid", 32'(bus.o_valid), 32'd0);
    begin
      int c;
      c = 0;
      while (!bus.i_imem_valid && c < 20) begin
        @(negedge clk);
        c++;
      end
      chk("halt_rsp_seen", 32'(bus.i_imem_valid), 32'd1);
    end
    @(negedge clk);
    chk("halted_req", 32'(bus.o_imem_req), 32'd0);
    repeat (4) @(negedge clk);
    chk("halted_req_hold", 32'(bus.o_imem_req), 32'd0);
    chk("halted_valid", 32'(bus.o_valid), 32'd0);

    // async reset mid-transaction, then restart at RESET_ADDR
    do_reset();
    wait_req_pending("ar");
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_req", 32'(bus.o_imem_req), 32'd0);
    chk("ar_halted", 32'(halted), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    expect_pops(32'h0, 2, 40, "restart");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
